// File: rtl/marmot_wb_pkg.sv
// Shared types and constants for the Marmot Wishbone initiator.
package marmot_wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    localparam int TO_CNT_W = 16;

    localparam logic [WB_DAT_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    // Writes always report zero data; reads pass the supplied word through.
    function automatic logic [WB_DAT_W-1:0] rsp_data(input logic we,
                                                     input logic [WB_DAT_W-1:0] rd);
        logic [WB_DAT_W-1:0] res;
        if (we) begin
            res = {WB_DAT_W{1'b0}};
        end else begin
            res = rd;
        end
        return res;
    endfunction

endpackage

// File: rtl/marmot_wb_initiator_if.sv
// Wishbone classic bus bundle between the initiator and the user-project slave.
interface marmot_wb_initiator_if;
    import marmot_wb_pkg::*;

    logic                cyc;
    logic                stb;
    logic                we;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat_o;
    logic [WB_DAT_W-1:0] dat_i;
    logic                ack;

    modport master (
        output cyc, stb, we, sel, adr, dat_o,
        input  dat_i, ack
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_o,
        output dat_i, ack
    );

endinterface

// File: rtl/marmot_wb_timeout.sv
// Saturating cycle counter that flags when a bus cycle has waited `limit` cycles.
// A limit of zero never expires.
module marmot_wb_timeout
    import marmot_wb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [TO_CNT_W-1:0] limit,
    output logic                expired
);

    logic [TO_CNT_W-1:0] cnt_q;
    logic [TO_CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {TO_CNT_W{1'b0}};
        end else if (en && (cnt_q != {TO_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {TO_CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (limit != 16'd0) && (cnt_q == (limit - 16'd1));

endmodule

// File: rtl/marmot_wb_initiator.sv
// Wishbone classic single-transfer initiator: one bus cycle per accepted
// command, one response per bus cycle, with a timeout so a silent slave
// produces an error response instead of a hang.
module marmot_wb_initiator
    import marmot_wb_pkg::*;
#(
    parameter int unsigned          TIMEOUT_CYCLES = 255,
    parameter logic [WB_DAT_W-1:0]  ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_we,
    input  logic [WB_ADR_W-1:0]    cmd_adr,
    input  logic [WB_DAT_W-1:0]    cmd_dat,
    input  logic [WB_SEL_W-1:0]    cmd_sel,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WB_DAT_W-1:0]    rsp_dat,
    output logic                   rsp_err,
    marmot_wb_initiator_if.master  wb
);

    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);

    wb_state_e           state_q,     state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                cyc_q,       cyc_d;
    logic                stb_q,       stb_d;
    logic                we_q,        we_d;
    logic [WB_SEL_W-1:0] sel_q,       sel_d;
    logic [WB_ADR_W-1:0] adr_q,       adr_d;
    logic [WB_DAT_W-1:0] dat_q,       dat_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q,   rsp_err_d;
    logic [WB_DAT_W-1:0] rsp_dat_q,   rsp_dat_d;
    logic                to_expired_s;

    // The timeout only runs while a bus cycle is open; any other state rearms it.
    marmot_wb_timeout u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q != BUS),
        .en      (state_q == BUS),
        .limit   (TO_LIMIT),
        .expired (to_expired_s)
    );

    // Next-state and datapath decode; every register holds unless a branch moves it.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = BUS;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                // Ack is checked first so a late ack beats the timeout.
                if (wb.ack) begin
                    rsp_dat_d   = rsp_data(we_q, wb.dat_i);
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    state_d     = RESP;
                end else if (to_expired_s) begin
                    rsp_dat_d   = rsp_data(we_q, ERR_DATA);
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    state_d     = RESP;
                end else begin
                    state_d = BUS;
                end
            end
            RESP: begin
                // Ack is ignored here, absorbing a registered slave's trailing ack.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset abandons any open cycle without a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0000_0000;
            dat_q       <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_dat   = rsp_dat_q;
    assign wb.cyc    = cyc_q;
    assign wb.stb    = stb_q;
    assign wb.we     = we_q;
    assign wb.sel    = sel_q;
    assign wb.adr    = adr_q;
    assign wb.dat_o  = dat_q;

endmodule

// File: tb/tb_marmot_wb_initiator.sv
// Directed testbench for marmot_wb_initiator with a configurable model slave.
module tb_marmot_wb_initiator;

    localparam logic [2:0] M_NONE   = 3'd0;
    localparam logic [2:0] M_COMB   = 3'd1;
    localparam logic [2:0] M_REG    = 3'd2;
    localparam logic [2:0] M_LATE   = 3'd3;
    localparam logic [2:0] M_ALWAYS = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    logic [2:0]  slv_mode;
    logic [31:0] slv_rdata;
    logic        reg_ack   = 1'b0;
    int          bus_cnt   = 0;
    int          cyc_total = 0;
    int          rsp_total = 0;
    int          n_pass    = 0;
    int          n_total   = 0;

    marmot_wb_initiator_if wb_if ();

    marmot_wb_initiator #(
        .TIMEOUT_CYCLES (4),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wb        (wb_if)
    );

    always #5 clk = ~clk;

    // Model slave: registered ack, cycle counter for the late-ack mode, and
    // running totals of bus-busy cycles and accepted responses.
    always @(posedge clk) begin
        reg_ack <= wb_if.cyc & wb_if.stb;
        if (wb_if.cyc & wb_if.stb) bus_cnt <= bus_cnt + 1;
        else                       bus_cnt <= 0;
        if (wb_if.cyc)               cyc_total <= cyc_total + 1;
        if (rsp_valid && rsp_ready)  rsp_total <= rsp_total + 1;
    end

    assign wb_if.dat_i = slv_rdata;
    assign wb_if.ack   = (slv_mode == M_COMB) ? (wb_if.cyc & wb_if.stb) :
                         (slv_mode == M_REG)  ? reg_ack :
                         (slv_mode == M_LATE) ? (wb_if.cyc & wb_if.stb & (bus_cnt == 3)) :
                         (slv_mode == M_ALWAYS);

    // Present a command; caller is at a negedge and the next posedge is E0.
    task automatic drive_cmd(input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (wb_if.cyc !== 1'b0 || wb_if.stb !== 1'b0) $display("FAIL rst_cycstb: got %b%b want 00", wb_if.cyc, wb_if.stb); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== 32'h0) $display("FAIL rst_rsp: got v=%b e=%b d=%h want 0/0/0", rsp_valid, rsp_err, rsp_dat); else n_pass++;
        n_total++; if (wb_if.adr !== 32'h0 || wb_if.dat_o !== 32'h0 || wb_if.sel !== 4'h0 || wb_if.we !== 1'b0) $display("FAIL rst_wbregs: got a=%h d=%h s=%h w=%b want zeros", wb_if.adr, wb_if.dat_o, wb_if.sel, wb_if.we); else n_pass++;
        n_total++; if (cmd_ready !== 1'b0) $display("FAIL rst_ready_in_reset: got %b want 0", cmd_ready); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_write_reg_ack;
        int c0, r0;
        slv_mode = M_REG;
        rsp_ready = 1'b1;
        c0 = cyc_total; r0 = rsp_total;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL wr_ready_pre: got %b want 1", cmd_ready); else n_pass++;
        drive_cmd(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
        @(posedge clk); @(negedge clk);  // after E0
        cmd_valid = 1'b0;
        n_total++; if (wb_if.adr !== 32'h3000_0004 || wb_if.dat_o !== 32'hA5A5_1234 || wb_if.sel !== 4'hF || wb_if.we !== 1'b1) $display("FAIL wr_bus_fields: got a=%h d=%h s=%h w=%b want 30000004/a5a51234/f/1", wb_if.adr, wb_if.dat_o, wb_if.sel, wb_if.we); else n_pass++;
        n_total++; if (wb_if.cyc !== 1'b1 || wb_if.stb !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL wr_e0_state: got cyc=%b stb=%b rdy=%b want 1/1/0", wb_if.cyc, wb_if.stb, cmd_ready); else n_pass++;
        @(posedge clk); @(negedge clk);  // after E1
        n_total++; if (rsp_valid !== 1'b0 || wb_if.cyc !== 1'b1) $display("FAIL wr_e1: got v=%b cyc=%b want 0/1", rsp_valid, wb_if.cyc); else n_pass++;
        @(posedge clk); @(negedge clk);  // after E2
        n_total++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0 || rsp_err !== 1'b0) $display("FAIL wr_e2_rsp: got v=%b d=%h e=%b want 1/0/0", rsp_valid, rsp_dat, rsp_err); else n_pass++;
        n_total++; if (wb_if.cyc !== 1'b0 || wb_if.stb !== 1'b0) $display("FAIL wr_e2_drop: got %b%b want 00", wb_if.cyc, wb_if.stb); else n_pass++;
        repeat (4) @(negedge clk);
        n_total++; if (cyc_total - c0 !== 2) $display("FAIL wr_cyc_len: got %0d want 2", cyc_total - c0); else n_pass++;
        n_total++; if (rsp_total - r0 !== 1 || rsp_valid !== 1'b0) $display("FAIL wr_rsp_count: got %0d v=%b want 1/0", rsp_total - r0, rsp_valid); else n_pass++;
    endtask

    task automatic test_read_comb_ack;
        int c0;
        slv_mode  = M_COMB;
        slv_rdata = 32'hCAFE_F00D;
        c0 = cyc_total;
        drive_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);  // after E1
        n_total++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'hCAFE_F00D || rsp_err !== 1'b0) $display("FAIL rd_e1_rsp: got v=%b d=%h e=%b want 1/cafef00d/0", rsp_valid, rsp_dat, rsp_err); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (cyc_total - c0 !== 1) $display("FAIL rd_cyc_len: got %0d want 1", cyc_total - c0); else n_pass++;
    endtask

    task automatic test_timeout;
        int c0;
        slv_mode  = M_NONE;
        slv_rdata = 32'h1111_2222;
        c0 = cyc_total;
        drive_cmd(1'b0, 32'h3000_0020, 32'h0, 4'h3);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end  // after E3
        n_total++; if (rsp_valid !== 1'b0 || wb_if.cyc !== 1'b1) $display("FAIL to_e3: got v=%b cyc=%b want 0/1", rsp_valid, wb_if.cyc); else n_pass++;
        @(posedge clk); @(negedge clk);  // after E4
        n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'hDEAD_BEEF) $display("FAIL to_e4_rsp: got v=%b e=%b d=%h want 1/1/deadbeef", rsp_valid, rsp_err, rsp_dat); else n_pass++;
        n_total++; if (cyc_total - c0 !== 4 || wb_if.cyc !== 1'b0) $display("FAIL to_cyc_len: got %0d cyc=%b want 4/0", cyc_total - c0, wb_if.cyc); else n_pass++;
        @(posedge clk); @(negedge clk);  // response consumed
        slv_mode = M_COMB;
        drive_cmd(1'b1, 32'h3000_0024, 32'h0000_0001, 4'h1);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0) $display("FAIL to_next_cmd: got v=%b e=%b d=%h want 1/0/0", rsp_valid, rsp_err, rsp_dat); else n_pass++;
        repeat (2) @(negedge clk);
        // A write that times out reports an error with zero data.
        slv_mode = M_NONE;
        drive_cmd(1'b1, 32'h3000_0028, 32'h5555_AAAA, 4'hC);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0) $display("FAIL to_write_rsp: got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_dat); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ack_on_last_cycle;
        int c0;
        slv_mode  = M_LATE;
        slv_rdata = 32'h1234_5678;
        c0 = cyc_total;
        drive_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end  // after E4
        n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h1234_5678) $display("FAIL late_ack_rsp: got v=%b e=%b d=%h want 1/0/12345678", rsp_valid, rsp_err, rsp_dat); else n_pass++;
        n_total++; if (cyc_total - c0 !== 4) $display("FAIL late_ack_len: got %0d want 4", cyc_total - c0); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure;
        int  r0;
        logic ok;
        slv_mode  = M_COMB;
        slv_rdata = 32'h0BAD_F00D;
        rsp_ready = 1'b0;
        r0 = rsp_total;
        drive_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        n_total++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0BAD_F00D) $display("FAIL bp_first: got v=%b d=%h want 1/0badf00d", rsp_valid, rsp_dat); else n_pass++;
        // Slave now acks every cycle with new data; the held response must not move.
        slv_mode  = M_ALWAYS;
        slv_rdata = 32'h7777_7777;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0BAD_F00D || rsp_err !== 1'b0 || cmd_ready !== 1'b0 || wb_if.cyc !== 1'b0) ok = 1'b0;
        end
        n_total++; if (ok !== 1'b1) $display("FAIL bp_hold: got v=%b d=%h e=%b rdy=%b cyc=%b want 1/0badf00d/0/0/0", rsp_valid, rsp_dat, rsp_err, cmd_ready, wb_if.cyc); else n_pass++;
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL bp_release: got v=%b rdy=%b want 0/1", rsp_valid, cmd_ready); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (rsp_total - r0 !== 1 || wb_if.cyc !== 1'b0) $display("FAIL bp_rsp_count: got %0d cyc=%b want 1/0", rsp_total - r0, wb_if.cyc); else n_pass++;
        slv_mode = M_NONE;
    endtask

    task automatic test_reset_mid_transfer;
        int r0;
        slv_mode  = M_NONE;
        rsp_ready = 1'b1;
        r0 = rsp_total;
        drive_cmd(1'b0, 32'h3000_0050, 32'h0, 4'hF);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        n_total++; if (wb_if.cyc !== 1'b1) $display("FAIL mid_in_bus: got cyc=%b want 1", wb_if.cyc); else n_pass++;
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        n_total++; if (wb_if.cyc !== 1'b0 || wb_if.stb !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || wb_if.adr !== 32'h0) $display("FAIL mid_rst_edge: got cyc=%b stb=%b v=%b rdy=%b a=%h want 0/0/0/0/0", wb_if.cyc, wb_if.stb, rsp_valid, cmd_ready, wb_if.adr); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL mid_ready_after: got %b want 1", cmd_ready); else n_pass++;
        repeat (6) @(negedge clk);
        n_total++; if (rsp_total - r0 !== 0 || rsp_valid !== 1'b0) $display("FAIL mid_no_rsp: got %0d v=%b want 0/0", rsp_total - r0, rsp_valid); else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0;
        cmd_dat   = 32'h0;
        cmd_sel   = 4'h0;
        rsp_ready = 1'b1;
        slv_mode  = M_NONE;
        slv_rdata = 32'h0;
        @(negedge clk);
        test_reset;
        test_write_reg_ack;
        test_read_comb_ack;
        test_timeout;
        test_ack_on_last_cycle;
        test_backpressure;
        test_reset_mid_transfer;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
